// File: rtl/mux5_rr_sched_if.sv
// rtl/mux5_rr_sched_if.sv - request/grant bundle between requesters and the round-robin mux scheduler
//
// Signals:
//   req     requester -> scheduler  5  level request, bit i = mux input i
//   gnt     scheduler -> requester  5  one-hot grant, zero when no owner
//   sel     scheduler -> mux        3  owner index 0..4, 3'b101 when no owner
//   busy    scheduler -> requester  1  OR of gnt
//   timeout scheduler -> requester  1  pulse: previous owner revoked by hold limit
interface mux5_rr_sched_if;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (output req, input gnt, input sel, input busy, input timeout);
  modport slave  (input req, output gnt, output sel, output busy, output timeout);
endinterface

// File: rtl/mux5_rr_sched.sv
// rtl/mux5_rr_sched.sv - round-robin owner scheduler driving the select of a 5x1 mux
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux5_rr_sched_if.slave: req in; gnt, sel, busy, timeout out (all registered)
module mux5_rr_sched #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux5_rr_sched_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    GAP   = 3'd2
  } state_t;

  // Code the mux treats as invalid; it forces the shared line to 0.
  localparam logic [2:0]        SEL_NONE  = 3'b101;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        cur_q, cur_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [4:0]        gnt_q, gnt_d;
  logic [2:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              win_found;
  logic [2:0]        win_idx;
  logic [3:0]        cand;

  // Round-robin search starting at ptr; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < 5; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'd5) begin
        cand = cand - 4'd5;
      end
      if (!win_found && bus.req[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d    = GRANT;
          cur_d      = win_idx;
          gnt_d      = 5'b00001 << win_idx;
          sel_d      = win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = 5'b00000;
          sel_d   = SEL_NONE;
          busy_d  = 1'b0;
        end
      end

      GRANT: begin
        // Release is checked first so a release coinciding with the limit
        // does not report a timeout.
        if (!bus.req[cur_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d   = GAP;
          gnt_d     = 5'b00000;
          sel_d     = SEL_NONE;
          busy_d    = 1'b0;
          ptr_d     = (cur_q == 3'd4) ? 3'd0 : cur_q + 3'd1;
          timeout_d = bus.req[cur_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 5'b00000;
        sel_d   = SEL_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      cur_q      <= 3'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 5'b00000;
      sel_q      <= SEL_NONE;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// tb/tb_mux5_rr_sched.sv - scoreboard bench for mux5_rr_sched with directed vectors
module tb_mux5_rr_sched;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mux5_rr_sched_if bus_if ();

  mux5_rr_sched #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       to;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per edge following a stimulus step.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if ((bus_if.busy !== (|bus_if.gnt)) || ((bus_if.sel == 3'b101) !== (bus_if.gnt == 5'b0)) ||
          ($countones(bus_if.gnt) > 1) || (bus_if.sel > 3'b101)) begin
        errors++;
        $display("FAIL invariant: gnt=%b sel=%b busy=%b", bus_if.gnt, bus_if.sel, bus_if.busy);
      end
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.timeout} !==
          {mon_e.gnt, mon_e.sel, mon_e.busy, mon_e.to}) begin
        errors++;
        $display("FAIL %s: got gnt=%b sel=%b busy=%b timeout=%b, expected gnt=%b sel=%b busy=%b timeout=%b",
                 mon_e.tag, bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.timeout,
                 mon_e.gnt, mon_e.sel, mon_e.busy, mon_e.to);
      end
    end
  end

  // owner 5 means no owner (sel parked at 3'b101).
  task automatic step(input logic [4:0] r, input int owner, input logic to, input string tag);
    exp_t x;
    @(negedge clk);
    bus_if.req = r;
    x.gnt  = (owner == 5) ? 5'b00000 : (5'b00001 << owner);
    x.sel  = 3'(owner);
    x.busy = (owner != 5);
    x.to   = to;
    x.tag  = tag;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_if.req = 5'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.timeout} !== {5'b00000, 3'b101, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b busy=%b timeout=%b, expected gnt=00000 sel=101 busy=0 timeout=0",
               tag, bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.timeout);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus_if.req = 5'b11111;
    #12;
    check_idle_outputs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset mid-grant with all requesting.
    step(5'b11111, 0, 1'b0, "t1_first_grant_0");
    step(5'b11111, 0, 1'b0, "t1_hold_0");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t1_async_reset_mid_grant");
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b11111, 0, 1'b0, "t1_post_reset_grant_0");
    step(5'b00000, 5, 1'b0, "t1_release_gap");
    step(5'b00000, 5, 1'b0, "t1_idle");

    // 2. Single requester releases after four grant cycles.
    for (int i = 0; i < 4; i++) step(5'b00100, 2, 1'b0, "t2_grant_2");
    step(5'b00000, 5, 1'b0, "t2_gap");
    step(5'b00000, 5, 1'b0, "t2_idle");

    // 3. Fair rotation from ptr=0.
    do_reset();
    begin
      int order[6] = '{0, 1, 2, 3, 4, 0};
      for (int n = 0; n < 6; n++) begin
        step(5'b11111, order[n], 1'b0, "t3_grant");
        step(5'b11111, order[n], 1'b0, "t3_hold");
        step(5'b11111 & ~(5'b00001 << order[n]), 5, 1'b0, "t3_gap");
      end
    end
    step(5'b00000, 5, 1'b0, "t3_idle");

    // 4. Lone requester hits the hold limit repeatedly.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) step(5'b10000, 4, 1'b0, "t4_grant_4");
      step(5'b10000, 5, 1'b1, "t4_timeout_gap");
    end
    step(5'b10000, 4, 1'b0, "t4_regrant_4");
    step(5'b00000, 5, 1'b0, "t4_release_gap");
    step(5'b00000, 5, 1'b0, "t4_idle");

    // 5. Two competitors alternate on the hold limit (ptr=0 now).
    for (int i = 0; i < 8; i++) step(5'b01010, 1, 1'b0, "t5_grant_1");
    step(5'b01010, 5, 1'b1, "t5_timeout_gap_1");
    for (int i = 0; i < 8; i++) step(5'b01010, 3, 1'b0, "t5_grant_3");
    step(5'b01010, 5, 1'b1, "t5_timeout_gap_3");
    step(5'b01010, 1, 1'b0, "t5_regrant_1");
    step(5'b00000, 5, 1'b0, "t5_release_gap");
    step(5'b00000, 5, 1'b0, "t5_idle");

    // 6. Release coincides with the limit (ptr=2, lone requester 0).
    for (int i = 0; i < 8; i++) step(5'b00001, 0, 1'b0, "t6_grant_0");
    step(5'b00000, 5, 1'b0, "t6_release_at_limit_no_timeout");
    step(5'b00011, 1, 1'b0, "t6_ptr_advanced_grant_1");
    step(5'b00000, 5, 1'b0, "t6_release_gap");
    step(5'b00000, 5, 1'b0, "t6_idle");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux5_rr_sched.md
Name: mux5_rr_sched

Overview:
- Round-robin scheduler that shares one 5-input mux output line among five requesters.
- Its sel output drives the select input of the 5x1 mux directly.
- The scheduler parks sel at 3'b101 whenever no owner exists. The mux defines that code as invalid and forces its output to 0, so the shared line reads 0.
- It enforces a one-cycle gap between owners and a bounded hold time, so one requester cannot starve the others.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership. Legal range 1..2^HOLD_W.
- HOLD_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  5  level request; bit i requests the mux input at select value i (a=0 .. e=4).
- gnt  output  5  one-hot grant, or all zero when there is no owner.
- sel  output  3  mux select: owner index 0..4, or 3'b101 when there is no owner.
- busy  output  1  high while gnt is non-zero.
- timeout  output  1  one-cycle pulse: the previous owner was revoked by the hold limit.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- All outputs are registered. There is no combinational path from req to any output.
- Reset values (asserted immediately on rst_n low, including mid-grant):
  - gnt=5'b00000, sel=3'b101, busy=0, timeout=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state=IDLE.
- State registers: 3-bit state (IDLE, GRANT, GAP), 3-bit ptr (0..4), 3-bit cur (owner index), HOLD_W-bit hold_cnt.
- Arbitration function (used in IDLE and GAP):
  - Select the first i with req[i]=1, searching ptr, ptr+1, ... with wrap 4->0.
  - The search examines all five bits.
- IDLE:
  - Outputs sel=3'b101, gnt=0.
  - On the edge where req!=0: cur<=winner, gnt<=one-hot(winner), sel<=winner, busy<=1, hold_cnt<=0, go to GRANT.
  - Latency: one edge from a request being sampled to the grant being visible.
- GRANT, evaluated each edge in this priority order:
  - (1) req[cur]==0 (release): go to GAP.
  - (2) hold_cnt==MAX_HOLD-1 (limit reached): go to GAP and set timeout<=1.
  - (3) Otherwise hold_cnt<=hold_cnt+1.
  - Result: a grant is visible for at most MAX_HOLD cycles.
  - On entry to GAP, in both cases (1) and (2): gnt<=0, sel<=3'b101, busy<=0, ptr<=(cur==4)?0:cur+1.
- GAP:
  - Lasts exactly one cycle; the shared line reads 0 during it.
  - timeout is high only during this cycle when GAP was entered by the limit; it clears on the next edge.
  - At the GAP exit edge, arbitrate using the updated ptr.
  - If any req is high, go to GRANT as in IDLE; otherwise go to IDLE.
  - A revoked requester that still holds req stays eligible. It gets lowest priority, and is re-granted if it is the only requester.
- Simultaneous release and limit on the same edge: release wins and timeout stays 0.
- A req bit for a non-owner dropping or rising mid-grant has no effect until the next arbitration.
- Invariants:
  - gnt is always one-hot or zero.
  - sel==3'b101 exactly when gnt==0.
  - sel never takes 3'b110 or 3'b111.
  - busy is the OR of gnt.

Test Plan:
1. Reset: hold req=5'b11111 and pulse rst_n low mid-grant between clock edges -> gnt=0, sel=3'b101, busy=0 immediately. After release, the first grant goes to index 0.
2. Single release: req=5'b00100 sampled at edge E1, dropped before E5 -> gnt=5'b00100 and sel=2 after E1 through E5. At E5, sel=3'b101 (GAP), then IDLE. timeout stays 0.
3. Fair rotation: req=5'b11111; each owner drops its bit for one cycle after 2 grant cycles, then reasserts. Required grant order: 0,1,2,3,4,0, with exactly one sel=3'b101 cycle between owners.
4. Hold limit, lone requester: MAX_HOLD=8, req=5'b10000 held. Required response:
   - gnt=5'b10000 for 8 cycles.
   - One GAP cycle with timeout=1.
   - Re-grant to 4, with ptr wrapped to 0.
   - The pattern repeats every 9 cycles.
5. Hold limit, competitor: req=5'b01010 held. Required response:
   - Grant 1 for 8 cycles, then GAP with timeout=1.
   - Grant 3 for 8 cycles, then GAP with timeout=1.
   - Grant 1 again.
6. Simultaneous event: the owner drops req on the same edge hold_cnt==MAX_HOLD-1 -> GAP is entered with timeout=0, and ptr advances normally.
